// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 8 * HDR_BYTES;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler: byte at lane 0 lands in bits [7:0].
// Latency: word and word_vld appear the cycle after the last-lane byte.
// Backpressure: none; the caller only presents accepted bytes.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    input  logic [1:0]  lane,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [31:0] shift_q;
    logic        last_lane;

    assign last_lane = (lane == 2'(WORD_BYTES - 1));

    // Bytes enter from the top, so after four shifts byte 0 sits in [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            word_dat <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= byte_vld & last_lane;
            if (byte_vld) begin
                shift_q <= {byte_dat, shift_q[31:8]};
                if (last_lane) begin
                    word_dat <= {byte_dat, shift_q[31:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory writes; core held in reset until done.
// Latency: one write pulse the cycle after each word's last byte; full byte-per-cycle throughput.
// Backpressure: byte_ready_o high while loading, low in reset/DONE/ERR. Macro IMEM_LOADER_CHKSUM_EN adds checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wr_inst_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state_q, state_d;
    logic [1:0]        lane_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  hdr_n;
    logic              xfer;
    logic              lane_last;
    logic              last_word;
    logic              word_vld;
    logic [31:0]       word_dat;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]        chk_q;
`endif

    assign byte_ready_o = rst_n & (state_q inside {HDR_LO, HDR_HI, DATA, CHK});
    assign xfer         = byte_valid_i & byte_ready_o;
    assign hdr_n        = {byte_data_i, cnt_q[7:0]};
    assign lane_last    = (lane_q == 2'(WORD_BYTES - 1));
    assign last_word    = (idx_q == cnt_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_LO: if (xfer) state_d = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    if (hdr_n == '0)                  state_d = END_ST;
                    else if (int'(hdr_n) > MAX_WORDS) state_d = ERR;
                    else                              state_d = DATA;
                end
            end
            DATA: if (xfer && lane_last && last_word) state_d = END_ST;
`ifdef IMEM_LOADER_CHKSUM_EN
            CHK: if (xfer) state_d = (byte_data_i == chk_q) ? DONE : ERR;
`endif
            default: state_d = state_q;
        endcase
    end

    // Address is latched with the last lane so it lines up with the packer's write pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            addr_q <= BASE_ADDR;
        end else if (xfer) begin
            case (state_q)
                HDR_LO: cnt_q[7:0]  <= byte_data_i;
                HDR_HI: cnt_q[15:8] <= byte_data_i;
                DATA: begin
                    lane_q <= lane_q + 2'd1;
                    if (lane_last) begin
                        addr_q <= BASE_ADDR + ADDR_W'({idx_q, 2'b00});
                        idx_q  <= idx_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else if (xfer && state_q == DATA) begin
            chk_q <= chk_q ^ byte_data_i;
        end
    end
`endif

    word_packer u_word_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .byte_vld (xfer && state_q == DATA),
        .byte_dat (byte_data_i),
        .lane     (lane_q),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    // DONE can be entered while the final write is still pulsing; done waits for it.
    assign wr_en_o   = word_vld;
    assign wr_inst_o = word_dat;
    assign addr_o    = addr_q;
    assign done_o    = (state_q == DONE) & ~word_vld;
    assign err_o     = (state_q == ERR);
    assign cpu_rst_o = ~done_o;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams, gaps, empty/oversize headers, checksum and mid-load reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] addr_o;
    logic [31:0] wr_inst_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] wa [8];
    logic [31:0] wd [8];
    int          wn = 0;
    logic        mon_rdy = 1'b0;
    int          ready_drop = 0;

    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h6F, 8'h00, 8'h00, 8'h00};

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .addr_o       (addr_o),
        .wr_inst_o    (wr_inst_o),
        .cpu_rst_o    (cpu_rst_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en_o) begin
            if (wn < 8) begin
                wa[wn] = addr_o;
                wd[wn] = wr_inst_o;
            end
            wn = wn + 1;
        end
        if (mon_rdy && rst_n && !byte_ready_o && !done_o && !err_o && !wr_en_o)
            ready_drop = ready_drop + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that took the byte.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        byte_valid_i = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        t = 0;
        while (!byte_ready_o && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $error("FAIL ready_timeout observed=%0d expected=<20", t);
        end
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},   32'(byte_ready_o), 32'd0);
        check({tag, "_wr_en"},   32'(wr_en_o),      32'd0);
        check({tag, "_addr"},    addr_o,            32'h0);
        check({tag, "_inst"},    wr_inst_o,         32'h0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst_o),    32'd1);
        check({tag, "_done"},    32'(done_o),       32'd0);
        check({tag, "_err"},     32'(err_o),        32'd0);
    endtask

    task automatic do_reset();
        byte_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        wn = 0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wn), 32'd2);
        check({tag, "_wa0"}, wa[0], 32'h0);
        check({tag, "_wd0"}, wd[0], 32'h00000013);
        check({tag, "_wa1"}, wa[1], 32'h4);
        check({tag, "_wd1"}, wd[1], 32'h0000006F);
    endtask

    initial begin
        // reset state
        #2;
        check_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(byte_ready_o), 32'd1);

        // continuous image
        for (int i = 0; i < 9; i++) send(img[i], 0);
        check("cont_pre_last_wr_en", 32'(wr_en_o), 32'd0);
        check("cont_first_addr_held", addr_o, 32'h0);
        send(img[9], 0);
        check("cont_last_wr_en", 32'(wr_en_o), 32'd1);
        check("cont_last_addr", addr_o, 32'h4);
        check("cont_last_inst", wr_inst_o, 32'h0000006F);
        check("cont_done_during_pulse", 32'(done_o), 32'd0);
`ifdef IMEM_LOADER_CHKSUM_EN
        send(8'h7C, 0);
`else
        tick();
`endif
        check("cont_done", 32'(done_o), 32'd1);
        check("cont_cpu_rst", 32'(cpu_rst_o), 32'd0);
        check("cont_ready_after", 32'(byte_ready_o), 32'd0);
        check("cont_err", 32'(err_o), 32'd0);
        check("cont_inst_hold", wr_inst_o, 32'h0000006F);
        check_two_writes("cont");

        // same image with random gaps
        do_reset();
        mon_rdy = 1'b1;
        for (int i = 0; i < 10; i++) send(img[i], int'($urandom_range(0, 3)));
`ifdef IMEM_LOADER_CHKSUM_EN
        send(8'h7C, int'($urandom_range(0, 3)));
`endif
        tick();
        mon_rdy = 1'b0;
        check("gap_done", 32'(done_o), 32'd1);
        check("gap_ready_drops", 32'(ready_drop), 32'd0);
        check_two_writes("gap");

        // empty image
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
`ifdef IMEM_LOADER_CHKSUM_EN
        send(8'h00, 0);
`endif
        check("empty_done", 32'(done_o), 32'd1);
        check("empty_cpu_rst", 32'(cpu_rst_o), 32'd0);
        tick();
        check("empty_writes", 32'(wn), 32'd0);

        // oversize header N = 1025
        do_reset();
        send(8'h01, 0);
        send(8'h04, 0);
        check("big_err", 32'(err_o), 32'd1);
        check("big_ready", 32'(byte_ready_o), 32'd0);
        check("big_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check("big_done", 32'(done_o), 32'd0);
        tick();
        check("big_writes", 32'(wn), 32'd0);

        // largest legal header N = 1024 must not error
        do_reset();
        send(8'h00, 0);
        send(8'h04, 0);
        check("max_err", 32'(err_o), 32'd0);
        check("max_ready", 32'(byte_ready_o), 32'd1);

`ifdef IMEM_LOADER_CHKSUM_EN
        // bad checksum
        do_reset();
        for (int i = 0; i < 10; i++) send(img[i], 0);
        send(8'h00, 0);
        check("badchk_err", 32'(err_o), 32'd1);
        check("badchk_done", 32'(done_o), 32'd0);
        check("badchk_cpu_rst", 32'(cpu_rst_o), 32'd1);
        check_two_writes("badchk");
`endif

        // reset mid-load, then full reload
        do_reset();
        for (int i = 0; i < 5; i++) send(img[i], 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        wn = 0;
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) send(img[i], 0);
`ifdef IMEM_LOADER_CHKSUM_EN
        send(8'h7C, 0);
`else
        tick();
`endif
        check("reload_done", 32'(done_o), 32'd1);
        check_two_writes("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer for the single-cycle core. Accepts a byte stream (UART receiver or debug bridge), assembles little-endian 32-bit words, and drives the write port of the instruction memory, which the core itself only reads. Holds the core in reset until the image is fully loaded, then releases it.

## Interface
- `ADDR_W`, 32, width of instruction memory address.
- `BASE_ADDR`, 32'h0, byte address of first loaded word.
- `MAX_WORDS`, 1024, largest accepted image in words; must be ≤ 65535.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_valid_i`  in  1  source has a byte.
- `byte_data_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `wr_en_o`  out  1  instruction memory write enable, one-cycle pulse per word.
- `addr_o`  out  ADDR_W  instruction memory byte address.
- `wr_inst_o`  out  32  instruction word to write.
- `cpu_rst_o`  out  1  active-high reset to PC/core; high until load completes.
- `done_o`  out  1  image loaded and verified; sticky.
- `err_o`  out  1  load failed; sticky.

## Operation
- Stream format: word count N (16-bit little-endian, 2 bytes), N×4 payload bytes (each word little-endian), then one checksum byte when the checksum feature is enabled.
- A byte transfers on a rising edge with `byte_valid_i & byte_ready_o`. The source must hold `byte_data_i` stable while valid is high and ready is low.
- FSM states:
  - HDR_LO → HDR_HI: on transfer.
  - HDR_HI: on transfer, N = 0 → CHK/DONE; N > MAX_WORDS → ERR; else → DATA.
  - DATA: byte lane counter 0..3 and word index 0..N-1. On the 4th lane, the assembled word is registered; word index increments; after the last word → CHK, or → DONE when the checksum feature is disabled.
  - CHK: on transfer, match → DONE; mismatch → ERR.
  - DONE, ERR: terminal. Only `rst_n` exits.
- `byte_ready_o` = 1 in HDR_LO, HDR_HI, DATA and CHK; 0 in DONE, ERR and reset.
- Address: `addr_o = BASE_ADDR + 4*index` (mod 2^ADDR_W). `addr_o` and `wr_inst_o` hold their last value between pulses.
- `cpu_rst_o = ~done_o`. `err_o` keeps the core in reset.
- Reset mid-load: all state clears and loading restarts at HDR_LO. Words already written stay in memory; no rollback.

## Timing
- Reset values: `byte_ready_o` 0, `wr_en_o` 0, `addr_o` BASE_ADDR, `wr_inst_o` 0, `cpu_rst_o` 1, `done_o` 0, `err_o` 0. `byte_ready_o` rises in the first cycle after `rst_n` deasserts.
- Full throughput: one byte per cycle, no bubbles. Word writes overlap the next word's bytes.
- `wr_en_o` is high for exactly the one cycle following the edge that accepts lane 3. `addr_o`/`wr_inst_o` are valid in that same cycle.
- `done_o` rises one cycle after the final `wr_en_o` pulse, or one cycle after the checksum byte is accepted, whichever is later.
- N = 0: `done_o` rises the cycle after the edge accepting the header high byte (or the checksum byte, if enabled). No writes occur.
- `err_o` rises the cycle after the offending byte is accepted.

## Configuration
- `IMEM_LOADER_CHKSUM_EN` defined:
  - CHK state exists.
  - Checksum = XOR of all N×4 payload bytes (header excluded; 8'h00 when N = 0).
  - Mismatch → ERR.
- Not defined:
  - No CHK state and no trailing byte.
  - DATA (or HDR_HI with N = 0) goes directly to DONE.
  - `err_o` is asserted only by the N > MAX_WORDS case.

## Structure
- Package `imem_loader_pkg`:
  - FSM state enum (HDR_LO, HDR_HI, DATA, CHK, DONE, ERR).
  - Header length constant (2 bytes) and word byte count (4).
- One sub-module, `word_packer`: shifts in bytes by lane, outputs the completed word plus a one-cycle `word_valid` pulse. The top-level FSM owns the counters, address, checksum and status.

## Test plan
- Continuous valid stream, bytes 02 00 | 13 00 00 00 | 6F 00 00 00 (+ checksum 7C if enabled) → two `wr_en_o` pulses: addr 0 with 32'h00000013, then addr 4 with 32'h0000006F. `done_o` = 1 and `cpu_rst_o` = 0 one cycle after the last pulse.
- Same image with random 0–3 cycle gaps in `byte_valid_i` → identical writes. No byte lost or duplicated. `byte_ready_o` never drops before DONE.
- Header 00 00 (+ 00 if enabled) → no `wr_en_o` pulse. `done_o` rises the following cycle.
- Header 01 04 (N = 1025, MAX_WORDS = 1024) → `err_o` = 1, `byte_ready_o` = 0, `cpu_rst_o` stays 1, no writes.
- With `IMEM_LOADER_CHKSUM_EN`: valid image plus checksum 00 instead of 7C → both writes occur, then `err_o` = 1 and `done_o` stays 0.
- Assert `rst_n` low after the 5th byte, then resend the full image → outputs return to reset values. The reload rewrites addr 0 first and completes normally.
